// File: rtl/sd_cmd_seq.sv
// ============================================================================
// sd_cmd_seq
// ----------------------------------------------------------------------------
// SD-card SPI-mode command sequencer. Sits in front of the SPI byte shifter
// and issues one complete command on a single start pulse. It computes the
// CRC7 of the command, shifts out the 6-byte frame, then polls with 0xFF
// bytes until an R1 response (bit 7 clear) arrives or the poll budget is
// exhausted.
//
// Parameters
//   RESP_MAX    maximum number of 0xFF poll bytes after the frame (1..255)
//   BSY_WAIT    clocks allowed between a shift trigger and shifter busy
//
// Ports
//   clk_i        system clock (shifter clock domain)
//   rst_n_i      asynchronous active-low reset
//   start_i      one-clock start pulse, only honoured when idle
//   cmd_idx_i6   command index, sampled with start_i
//   cmd_arg_i32  command argument, sampled with start_i
//   busy_o       sequence in progress
//   done_o       one-clock pulse at the end of every sequence
//   r1_o8        captured R1 byte (0xFF on timeout or error)
//   timeout_o    last sequence ran out of poll bytes
//   err_o        last sequence aborted because the shifter never went busy
//   sttshift_o   one-clock shift trigger to the shifter
//   ssptdat_o8   TX byte to the shifter
//   sspsreg_i8   RX byte from the shifter, valid once busy falls
//   sspbusy_i    shifter busy flag
// ============================================================================
module sd_cmd_seq #(
    parameter int RESP_MAX = 8,
    parameter int BSY_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [5:0]  cmd_idx_i6,
    input  logic [31:0] cmd_arg_i32,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  r1_o8,
    output logic        timeout_o,
    output logic        err_o,
    output logic        sttshift_o,
    output logic [7:0]  ssptdat_o8,
    input  logic [7:0]  sspsreg_i8,
    input  logic        sspbusy_i
);

    // Wait counter must be able to hold BSY_WAIT+1 without wrapping.
    localparam int                WAIT_W     = $clog2(BSY_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(BSY_WAIT);
    localparam logic [7:0]        POLL_LIMIT = 8'(RESP_MAX);

    typedef enum logic [3:0] {
        IDLE,
        CRC,
        SEND,
        WBSY,
        WEND,
        PSEND,
        PWBSY,
        PWEND,
        DONE
    } state_e;

    state_e             state_q, state_d;

    logic [5:0]         cmdIdx_q, cmdIdx_d;
    logic [31:0]        cmdArg_q, cmdArg_d;
    logic [6:0]         crc_q, crc_d;
    logic [5:0]         bitCnt_q, bitCnt_d;
    logic [2:0]         byteCnt_q, byteCnt_d;
    logic [7:0]         pollCnt_q, pollCnt_d;
    logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         r1_q, r1_d;
    logic               timeout_q, timeout_d;
    logic               err_q, err_d;
    logic               stt_q, stt_d;
    logic [7:0]         txDat_q, txDat_d;

    logic [39:0]        frameBits;
    logic [5:0]         bitIdx;
    logic               crcFb;
    logic [6:0]         crcNext;
    logic [7:0]         frameByte;
    logic               startAccept;

    assign startAccept = (state_q == IDLE) && start_i;

    // The CRC walks the 40 header bits MSB first, one bit per clock.
    // Feedback taps for x^7 + x^3 + 1 land on bits 3 and 0.
    assign frameBits = {2'b01, cmdIdx_q, cmdArg_q};
    assign bitIdx    = 6'd39 - bitCnt_q;
    assign crcFb     = frameBits[bitIdx] ^ crc_q[6];
    assign crcNext   = {crc_q[5:0], 1'b0} ^ {3'b000, crcFb, 2'b00, crcFb};

    // Frame byte selected by the byte counter value that will be live in
    // SEND, so the TX byte is registered together with the trigger.
    always_comb begin
        frameByte = 8'hFF;
        case (byteCnt_d)
            3'd0:    frameByte = {2'b01, cmdIdx_q};
            3'd1:    frameByte = cmdArg_q[31:24];
            3'd2:    frameByte = cmdArg_q[23:16];
            3'd3:    frameByte = cmdArg_q[15:8];
            3'd4:    frameByte = cmdArg_q[7:0];
            3'd5:    frameByte = {crc_q, 1'b1};
            default: frameByte = 8'hFF;
        endcase
    end

    // State register plus all datapath and output registers. Reset forces
    // every output to its idle value immediately, even mid-byte.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cmdIdx_q  <= '0;
            cmdArg_q  <= '0;
            crc_q     <= '0;
            bitCnt_q  <= '0;
            byteCnt_q <= '0;
            pollCnt_q <= '0;
            waitCnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r1_q      <= 8'hFF;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            stt_q     <= 1'b0;
            txDat_q   <= 8'hFF;
        end else begin
            state_q   <= state_d;
            cmdIdx_q  <= cmdIdx_d;
            cmdArg_q  <= cmdArg_d;
            crc_q     <= crc_d;
            bitCnt_q  <= bitCnt_d;
            byteCnt_q <= byteCnt_d;
            pollCnt_q <= pollCnt_d;
            waitCnt_q <= waitCnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            r1_q      <= r1_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            stt_q     <= stt_d;
            txDat_q   <= txDat_d;
        end
    end

    // Next-state logic. Both busy-wait states share the same abort path
    // when the shifter fails to raise busy within the allowed window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_i) state_d = CRC;
            CRC:   if (bitCnt_q == 6'd39) state_d = SEND;
            SEND:  state_d = WBSY;
            WBSY: begin
                if (sspbusy_i)                    state_d = WEND;
                else if (waitCnt_q == WAIT_LIMIT) state_d = DONE;
            end
            WEND: begin
                if (!sspbusy_i) state_d = (byteCnt_q < 3'd5) ? SEND : PSEND;
            end
            PSEND: state_d = PWBSY;
            PWBSY: begin
                if (sspbusy_i)                    state_d = PWEND;
                else if (waitCnt_q == WAIT_LIMIT) state_d = DONE;
            end
            PWEND: begin
                if (!sspbusy_i) begin
                    if (!sspsreg_i8[7] || (pollCnt_q == POLL_LIMIT)) state_d = DONE;
                    else                                             state_d = PSEND;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath counters and the latched command.
    always_comb begin
        cmdIdx_d  = cmdIdx_q;
        cmdArg_d  = cmdArg_q;
        crc_d     = crc_q;
        bitCnt_d  = bitCnt_q;
        byteCnt_d = byteCnt_q;
        pollCnt_d = pollCnt_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cmdIdx_d  = cmd_idx_i6;
                    cmdArg_d  = cmd_arg_i32;
                    crc_d     = '0;
                    bitCnt_d  = '0;
                    byteCnt_d = '0;
                    pollCnt_d = '0;
                end
            end
            CRC: begin
                crc_d    = crcNext;
                bitCnt_d = bitCnt_q + 6'd1;
            end
            SEND: waitCnt_d = '0;
            PSEND: begin
                waitCnt_d = '0;
                pollCnt_d = pollCnt_q + 8'd1;
            end
            WBSY, PWBSY: begin
                if (!sspbusy_i) waitCnt_d = waitCnt_q + 1'b1;
            end
            WEND: begin
                if (!sspbusy_i && (byteCnt_q < 3'd5)) byteCnt_d = byteCnt_q + 3'd1;
            end
            default: ;
        endcase
    end

    // Output logic, decoded from the upcoming state so every output comes
    // straight from a flop. The reason for entering DONE decides which of
    // r1/timeout/err gets updated.
    always_comb begin
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        stt_d     = (state_d == SEND) || (state_d == PSEND);
        txDat_d   = txDat_q;
        r1_d      = r1_q;
        timeout_d = timeout_q;
        err_d     = err_q;

        case (state_d)
            IDLE:    txDat_d = 8'hFF;
            SEND:    txDat_d = frameByte;
            PSEND:   txDat_d = 8'hFF;
            default: ;
        endcase

        if (startAccept) begin
            timeout_d = 1'b0;
            err_d     = 1'b0;
        end

        if (state_d == DONE) begin
            if ((state_q == WBSY) || (state_q == PWBSY)) begin
                err_d = 1'b1;
                r1_d  = 8'hFF;
            end else if (!sspsreg_i8[7]) begin
                r1_d = sspsreg_i8;
            end else begin
                timeout_d = 1'b1;
                r1_d      = 8'hFF;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign r1_o8      = r1_q;
    assign timeout_o  = timeout_q;
    assign err_o      = err_q;
    assign sttshift_o = stt_q;
    assign ssptdat_o8 = txDat_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// ============================================================================
// tb_sd_cmd_seq
// ----------------------------------------------------------------------------
// Directed bench for sd_cmd_seq. A behavioural shifter model answers every
// trigger; expected TX bytes and the RX byte to return for each transfer are
// queued before a command is started and consumed as triggers arrive.
// ============================================================================
module tb_sd_cmd_seq;

    localparam int RESP_MAX  = 8;
    localparam int BSY_WAIT  = 15;
    localparam int BYTE_CLKS = 4;
    localparam int BUDGET    = 400;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [5:0]  cmd_idx_i6;
    logic [31:0] cmd_arg_i32;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  r1_o8;
    logic        timeout_o;
    logic        err_o;
    logic        sttshift_o;
    logic [7:0]  ssptdat_o8;
    logic [7:0]  sspsreg_i8;
    logic        sspbusy_i;

    int compareCount = 0;
    int failCount    = 0;
    int cycle        = 0;

    logic [7:0] expTx[$];
    logic [7:0] rxPlan[$];
    int         trigCycles[$];
    int         doneCycles[$];

    bit stuckLow   = 1'b0;
    bit skipStable = 1'b0;
    int startCycle;
    int trigBase;
    int doneBase;

    sd_cmd_seq #(
        .RESP_MAX(RESP_MAX),
        .BSY_WAIT(BSY_WAIT)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .cmd_idx_i6 (cmd_idx_i6),
        .cmd_arg_i32(cmd_arg_i32),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .r1_o8      (r1_o8),
        .timeout_o  (timeout_o),
        .err_o      (err_o),
        .sttshift_o (sttshift_o),
        .ssptdat_o8 (ssptdat_o8),
        .sspsreg_i8 (sspsreg_i8),
        .sspbusy_i  (sspbusy_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepNeg();
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] crcByte(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] bits;
        logic [6:0]  c;
        logic        fb;
        bits = {2'b01, idx, arg};
        c    = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return {c, 1'b1};
    endfunction

    task automatic pushFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        expTx.push_back(b0); expTx.push_back(b1); expTx.push_back(b2);
        expTx.push_back(b3); expTx.push_back(b4); expTx.push_back(b5);
        repeat (6) rxPlan.push_back(8'hFF);
    endtask

    task automatic pushPoll(input logic [7:0] resp);
        expTx.push_back(8'hFF);
        rxPlan.push_back(resp);
    endtask

    // Drives one start pulse (optionally advancing to a fresh negedge first)
    // and snapshots the monitor queues so per-command counts can be taken.
    task automatic applyStimulus(input bit doStep, input logic [5:0] idx, input logic [31:0] arg);
        if (doStep) stepNeg();
        trigBase = trigCycles.size();
        doneBase = doneCycles.size();
        checkOutput("busyBeforeStart", busy_o, 1'b0);
        cmd_idx_i6  = idx;
        cmd_arg_i32 = arg;
        start_i     = 1'b1;
        startCycle  = cycle;
        stepNeg();
        start_i     = 1'b0;
        cmd_idx_i6  = ~idx;
        cmd_arg_i32 = ~arg;
        checkOutput("busyAfterStart", busy_o, 1'b1);
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < BUDGET) begin
            stepNeg();
            n++;
        end
        checkOutput("doneSeen", done_o, 1'b1);
    endtask

    task automatic waitTrig(input int count);
        int n;
        n = 0;
        while ((trigCycles.size() - trigBase) < count && n < BUDGET) begin
            stepNeg();
            n++;
        end
        checkOutput("trigReached", trigCycles.size() - trigBase, count);
    endtask

    task automatic checkResult(input string tag, input logic [7:0] r1, input logic to,
                               input logic er, input int trigs);
        checkOutput({tag, ".r1"}, r1_o8, r1);
        checkOutput({tag, ".timeout"}, timeout_o, to);
        checkOutput({tag, ".err"}, err_o, er);
        checkOutput({tag, ".trigs"}, trigCycles.size() - trigBase, trigs);
        checkOutput({tag, ".doneCount"}, doneCycles.size() - doneBase, 1);
        checkOutput({tag, ".txLeft"}, expTx.size(), 0);
    endtask

    // Shifter model: goes busy the clock after a trigger, holds for a byte
    // time, then presents the planned RX byte as busy falls.
    initial begin : shifterModel
        logic [7:0] tx;
        logic [7:0] rx;
        sspbusy_i  = 1'b0;
        sspsreg_i8 = 8'hFF;
        forever begin
            @(posedge clk_i);
            if (sttshift_o === 1'b1) begin
                tx = ssptdat_o8;
                if (expTx.size() == 0) checkOutput("unexpectedTrig", 1'b1, 1'b0);
                else                   checkOutput("txByte", tx, expTx.pop_front());
                rx = (rxPlan.size() != 0) ? rxPlan.pop_front() : 8'hFF;
                if (!stuckLow) begin
                    #1 sspbusy_i = 1'b1;
                    repeat (BYTE_CLKS) @(posedge clk_i);
                    if (!skipStable) checkOutput("txStable", ssptdat_o8, tx);
                    #1;
                    sspsreg_i8 = rx;
                    sspbusy_i  = 1'b0;
                end
            end
        end
    end

    // Negedge monitor: logs trigger and done cycles, and flags any trigger
    // raised while the shifter is still busy.
    initial begin : outputMonitor
        forever begin
            @(negedge clk_i);
            if (sttshift_o === 1'b1) begin
                checkOutput("trigWhileBusy", sspbusy_i, 1'b0);
                trigCycles.push_back(cycle);
            end
            if (done_o === 1'b1) doneCycles.push_back(cycle);
        end
    end

    initial begin : mainSequence
        logic [7:0] crc16;
        logic [7:0] crc17;
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        cmd_idx_i6  = '0;
        cmd_arg_i32 = '0;
        repeat (3) stepNeg();

        checkOutput("rst.busy", busy_o, 1'b0);
        checkOutput("rst.done", done_o, 1'b0);
        checkOutput("rst.stt", sttshift_o, 1'b0);
        checkOutput("rst.txdat", ssptdat_o8, 8'hFF);
        checkOutput("rst.r1", r1_o8, 8'hFF);
        checkOutput("rst.timeout", timeout_o, 1'b0);
        checkOutput("rst.err", err_o, 1'b0);
        rst_n_i = 1'b1;
        repeat (2) stepNeg();

        $display("[TB] CMD0: one 0xFF poll, then R1=0x01");
        pushFrame(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95);
        pushPoll(8'hFF);
        pushPoll(8'h01);
        applyStimulus(1'b1, 6'd0, 32'h0);
        waitDone();
        checkResult("cmd0", 8'h01, 1'b0, 1'b0, 8);
        stepNeg();
        checkOutput("cmd0.donePulse", done_o, 1'b0);
        checkOutput("cmd0.idle", busy_o, 1'b0);

        $display("[TB] CMD8: response on first poll, trigger latency");
        pushFrame(8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87);
        pushPoll(8'h01);
        applyStimulus(1'b1, 6'd8, 32'h0000_01AA);
        waitDone();
        checkResult("cmd8", 8'h01, 1'b0, 1'b0, 7);
        checkOutput("cmd8.firstTrigLatency",
                    (trigCycles.size() > trigBase) ? trigCycles[trigBase] - startCycle : -1, 41);
        stepNeg();

        $display("[TB] CMD55: no response, poll budget exhausted");
        pushFrame(8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65);
        for (int i = 0; i < RESP_MAX; i++) pushPoll(8'hFF);
        applyStimulus(1'b1, 6'd55, 32'h0);
        waitDone();
        checkResult("cmd55", 8'hFF, 1'b1, 1'b0, 6 + RESP_MAX);
        stepNeg();

        $display("[TB] Shifter never goes busy on first trigger");
        stuckLow = 1'b1;
        expTx.push_back(8'h40);
        rxPlan.push_back(8'hFF);
        applyStimulus(1'b1, 6'd0, 32'h0);
        waitDone();
        checkResult("stuck", 8'hFF, 1'b0, 1'b1, 1);
        checkOutput("stuck.errLatency",
                    (trigCycles.size() > trigBase) ? doneCycles[doneBase] - trigCycles[trigBase] : -1,
                    BSY_WAIT + 2);
        stuckLow = 1'b0;
        stepNeg();
        checkOutput("stuck.idle", busy_o, 1'b0);

        $display("[TB] ACMD41 with a stray start during frame byte 2");
        pushFrame(8'h69, 8'h40, 8'h00, 8'h00, 8'h00, 8'h77);
        pushPoll(8'h00);
        applyStimulus(1'b1, 6'd41, 32'h4000_0000);
        waitTrig(3);
        cmd_idx_i6  = 6'h3F;
        cmd_arg_i32 = 32'hFFFF_FFFF;
        start_i     = 1'b1;
        stepNeg();
        start_i     = 1'b0;
        checkOutput("acmd41.stillBusy", busy_o, 1'b1);
        waitDone();
        checkResult("acmd41", 8'h00, 1'b0, 1'b0, 7);

        $display("[TB] Back-to-back: CMD16 then CMD17 with start held over done");
        crc16 = crcByte(6'd16, 32'h0000_0200);
        crc17 = crcByte(6'd17, 32'h0000_1000);
        stepNeg();
        pushFrame(8'h50, 8'h00, 8'h00, 8'h02, 8'h00, crc16);
        pushPoll(8'h01);
        applyStimulus(1'b1, 6'd16, 32'h0000_0200);
        waitDone();
        checkResult("cmd16", 8'h01, 1'b0, 1'b0, 7);
        cmd_idx_i6  = 6'h3F;
        cmd_arg_i32 = 32'hDEAD_BEEF;
        start_i     = 1'b1;
        stepNeg();
        checkOutput("cmd16.donePulse", done_o, 1'b0);
        checkOutput("cmd16.startWithDoneIgnored", busy_o, 1'b0);
        pushFrame(8'h51, 8'h00, 8'h00, 8'h10, 8'h00, crc17);
        pushPoll(8'hFF);
        pushPoll(8'hFF);
        pushPoll(8'h05);
        applyStimulus(1'b0, 6'd17, 32'h0000_1000);
        waitDone();
        checkResult("cmd17", 8'h05, 1'b0, 1'b0, 9);
        stepNeg();

        $display("[TB] CMD58 with reset during frame byte 3");
        pushFrame(8'h7A, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD);
        pushPoll(8'h01);
        applyStimulus(1'b1, 6'd58, 32'h0);
        waitTrig(4);
        stepNeg();
        skipStable = 1'b1;
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("midRst.busy", busy_o, 1'b0);
        checkOutput("midRst.done", done_o, 1'b0);
        checkOutput("midRst.stt", sttshift_o, 1'b0);
        checkOutput("midRst.txdat", ssptdat_o8, 8'hFF);
        checkOutput("midRst.r1", r1_o8, 8'hFF);
        checkOutput("midRst.timeout", timeout_o, 1'b0);
        checkOutput("midRst.err", err_o, 1'b0);
        repeat (3) stepNeg();
        rst_n_i = 1'b1;
        repeat (40) stepNeg();
        checkOutput("midRst.noMoreTrigs", trigCycles.size() - trigBase, 4);
        checkOutput("midRst.noDone", doneCycles.size() - doneBase, 0);
        checkOutput("midRst.idle", busy_o, 1'b0);
        checkOutput("midRst.txLeft", expTx.size(), 3);
        expTx.delete();
        rxPlan.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
